// File: rtl/pixel_array_controller_if.sv
// Signal bundle between the pixel array sequencer, the PIXEL_SENSOR array and the downstream row consumer.
// data_valid is a one-cycle strobe with no ready: the consumer must take data_out/row_idx on the cycle it is high.
interface pixel_array_controller_if #(
    parameter int PIXEL_BITS = 8,
    parameter int COLS       = 2,
    parameter int ROWS       = 2
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                       start;
    logic                       continuous;
    logic                       erase;
    logic                       expose;
    logic                       ramp_enable;
    logic [PIXEL_BITS-1:0]      counter;
    logic [ROWS-1:0]            read_row;
    logic [COLS*PIXEL_BITS-1:0] data_in;
    logic [COLS*PIXEL_BITS-1:0] data_out;
    logic [ROW_W-1:0]           row_idx;
    logic                       data_valid;
    logic                       frame_done;
    logic                       busy;
    logic [2:0]                 dbg_state;

    modport master (
        input  start, continuous, data_in,
        output erase, expose, ramp_enable, counter, read_row,
               data_out, row_idx, data_valid, frame_done, busy, dbg_state
    );

    modport slave (
        output start, continuous, data_in,
        input  erase, expose, ramp_enable, counter, read_row,
               data_out, row_idx, data_valid, frame_done, busy, dbg_state
    );
endinterface

// File: rtl/pixel_array_controller.sv
// Frame sequencer for the pixel array: ERASE, EXPOSE, CONVERT (ramp + counter) and per-row READ,
// with a one-cycle GAP between phases. Every output is a register updated from the current state.
module pixel_array_controller #(
    parameter int PIXEL_BITS = 8,
    parameter int COLS       = 2,
    parameter int ROWS       = 2,
    parameter int C_ERASE    = 5,
    parameter int C_EXPOSE   = 255,
    parameter int C_CONVERT  = 256,
    parameter int C_READ     = 5
) (
    input logic                      clk,
    input logic                      reset,
    pixel_array_controller_if.master bus
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int MAX_A = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
    localparam int MAX_B = (C_CONVERT > C_READ) ? C_CONVERT : C_READ;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    logic [2:0]       state;
    logic [2:0]       gap_next;   // phase entered after GAP; S_IDLE marks end of frame
    logic [CNT_W-1:0] cnt;
    logic [ROW_W-1:0] row;

    assign bus.dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            gap_next        <= S_IDLE;
            cnt             <= '0;
            row             <= '0;
            bus.erase       <= 1'b0;
            bus.expose      <= 1'b0;
            bus.ramp_enable <= 1'b0;
            bus.counter     <= '0;
            bus.read_row    <= '0;
            bus.data_out    <= '0;
            bus.row_idx     <= '0;
            bus.data_valid  <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_ERASE;
                        cnt       <= '0;
                        bus.erase <= 1'b1;
                        bus.busy  <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (cnt == CNT_W'(C_ERASE - 1)) begin
                        state     <= S_GAP;
                        gap_next  <= S_EXPOSE;
                        bus.erase <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_EXPOSE: begin
                    if (cnt == CNT_W'(C_EXPOSE - 1)) begin
                        state      <= S_GAP;
                        gap_next   <= S_CONVERT;
                        bus.expose <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_CONVERT: begin
                    // Counter saturates at all-ones when the convert window outlasts the code range.
                    if (cnt == CNT_W'(C_CONVERT - 1)) begin
                        state           <= S_GAP;
                        gap_next        <= S_READ;
                        bus.ramp_enable <= 1'b0;
                        bus.counter     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (bus.counter != '1) begin
                            bus.counter <= bus.counter + PIXEL_BITS'(1);
                        end
                    end
                end
                S_READ: begin
                    if (cnt == CNT_W'(C_READ - 1)) begin
                        state          <= S_GAP;
                        bus.read_row   <= '0;
                        bus.data_out   <= bus.data_in;
                        bus.row_idx    <= row;
                        bus.data_valid <= 1'b1;
                        if (row == ROW_W'(ROWS - 1)) begin
                            gap_next       <= S_IDLE;
                            row            <= '0;
                            bus.frame_done <= 1'b1;
                        end else begin
                            gap_next <= S_READ;
                            row      <= row + ROW_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    cnt <= '0;
                    case (gap_next)
                        S_EXPOSE: begin
                            state      <= S_EXPOSE;
                            bus.expose <= 1'b1;
                        end
                        S_CONVERT: begin
                            state           <= S_CONVERT;
                            bus.ramp_enable <= 1'b1;
                        end
                        S_READ: begin
                            state        <= S_READ;
                            bus.read_row <= ROWS'(1) << row;
                        end
                        default: begin
                            if (bus.continuous) begin
                                state     <= S_ERASE;
                                bus.erase <= 1'b1;
                            end else begin
                                state    <= S_IDLE;
                                bus.busy <= 1'b0;
                            end
                        end
                    endcase
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_array_controller.sv
// Directed bench for pixel_array_controller: cycle-exact frame traces against a timing model,
// counter saturation on a second instance, continuous mode, start filtering and mid-frame reset.
module tb_pixel_array_controller;
    localparam int PB  = 8;
    localparam int CO  = 2;
    localparam int RO  = 2;
    localparam int CE  = 5;
    localparam int CX  = 255;
    localparam int CC  = 256;
    localparam int CR  = 5;
    localparam int DW  = PB * CO;
    localparam int RW  = 1;
    localparam int LEN = CE + CX + CC + 3 + RO * (CR + 1);
    localparam int RB  = CE + CX + CC + 4;

    typedef struct packed {
        logic          erase;
        logic          expose;
        logic          ramp;
        logic [PB-1:0] counter;
        logic [RO-1:0] read_row;
        logic          dv;
        logic          fd;
        logic          busy;
        logic [DW-1:0] dout;
        logic [RW-1:0] row_idx;
    } snap_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_dout = '0;
    logic [RW-1:0] exp_ridx = '0;

    pixel_array_controller_if #(.PIXEL_BITS(PB), .COLS(CO), .ROWS(RO)) bus ();
    pixel_array_controller_if #(.PIXEL_BITS(PB), .COLS(CO), .ROWS(RO)) bus2 ();

    pixel_array_controller #(
        .PIXEL_BITS(PB), .COLS(CO), .ROWS(RO),
        .C_ERASE(CE), .C_EXPOSE(CX), .C_CONVERT(CC), .C_READ(CR)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

    pixel_array_controller #(
        .PIXEL_BITS(PB), .COLS(CO), .ROWS(RO),
        .C_ERASE(2), .C_EXPOSE(3), .C_CONVERT(300), .C_READ(2)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.master)
    );

    // clock / reset
    always #5 clk = ~clk;

    // invariant monitor over both instances
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (!$onehot0({bus.erase, bus.expose, bus.ramp_enable, |bus.read_row}) ||
                !$onehot0(bus.read_row) || (!bus.ramp_enable && bus.counter != '0)) begin
                errors++;
                $display("FAIL invariant dut: erase=%b expose=%b ramp=%b read_row=%b counter=%0d required one-hot controls, counter 0 when ramp low",
                         bus.erase, bus.expose, bus.ramp_enable, bus.read_row, bus.counter);
            end
            checks++;
            if (!$onehot0({bus2.erase, bus2.expose, bus2.ramp_enable, |bus2.read_row}) ||
                !$onehot0(bus2.read_row) || (!bus2.ramp_enable && bus2.counter != '0)) begin
                errors++;
                $display("FAIL invariant dut2: erase=%b expose=%b ramp=%b read_row=%b counter=%0d required one-hot controls, counter 0 when ramp low",
                         bus2.erase, bus2.expose, bus2.ramp_enable, bus2.read_row, bus2.counter);
            end
        end
    end

    // Expected control outputs in cycle n of a run of back-to-back frames (cycle 1 follows the start edge).
    function automatic snap_t model(input int n, input int frames);
        snap_t s;
        int m, k, r, p, c;
        s = '0;
        if (n < 1 || n > frames * LEN) return s;
        m = (n - 1) % LEN + 1;
        s.busy = 1'b1;
        if (m <= CE) begin
            s.erase = 1'b1;
        end else if (m >= CE + 2 && m <= CE + 1 + CX) begin
            s.expose = 1'b1;
        end else if (m >= CE + CX + 3 && m <= CE + CX + 2 + CC) begin
            s.ramp = 1'b1;
            c = m - (CE + CX + 3);
            s.counter = PB'((c > 255) ? 255 : c);
        end else if (m >= RB) begin
            k = m - RB;
            r = k / (CR + 1);
            p = k % (CR + 1);
            if (p < CR) begin
                s.read_row = RO'(1 << r);
            end else begin
                s.dv = 1'b1;
                s.row_idx = RW'(r);
                s.fd = (r == RO - 1);
            end
        end
        return s;
    endfunction

    // driver: runs frames on dut from a start edge and compares every cycle against the model
    task automatic trace(input int frames, input int hold, input int repulse, input int abort_at,
                         input logic [DW-1:0] r0, input logic [DW-1:0] r1, input string tag);
        snap_t e, o;
        int last, m, k;
        last = (abort_at > 0) ? abort_at : frames * LEN + 3;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            if (n == hold) bus.start = 1'b0;
            if (repulse > 0 && n == repulse) bus.start = 1'b1;
            if (repulse > 0 && n == repulse + 1) bus.start = 1'b0;
            bus.continuous = (n <= (frames - 1) * LEN);
            m = (n - 1) % LEN + 1;
            k = m - RB;
            if (n <= frames * LEN && k >= 0 && k < CR) bus.data_in = r0;
            else if (n <= frames * LEN && k >= CR + 1 && k < 2 * CR + 1) bus.data_in = r1;
            else bus.data_in = DW'(n * 16'h1357) ^ 16'hDEAD;
            e = model(n, frames);
            if (e.dv) begin
                exp_dout = (e.row_idx == 1'b1) ? r1 : r0;
                exp_ridx = e.row_idx;
            end
            e.dout = exp_dout;
            e.row_idx = exp_ridx;
            o.erase = bus.erase;
            o.expose = bus.expose;
            o.ramp = bus.ramp_enable;
            o.counter = bus.counter;
            o.read_row = bus.read_row;
            o.dv = bus.data_valid;
            o.fd = bus.frame_done;
            o.busy = bus.busy;
            o.dout = bus.data_out;
            o.row_idx = bus.row_idx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got {erase,expose,ramp,counter,read_row,valid,done,busy,data_out,row_idx}=%h required %h",
                         tag, n, o, e);
            end
        end
        bus.data_in = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.erase, bus.expose, bus.ramp_enable, bus.counter, bus.read_row, bus.data_out,
             bus.row_idx, bus.data_valid, bus.frame_done, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_values: got nonzero outputs data_out=%h busy=%b required all 0",
                     bus.data_out, bus.busy);
        end
        checks++;
        if (bus2.busy !== 1'b0 || bus2.counter !== '0) begin
            errors++;
            $display("FAIL reset_values_dut2: busy=%b counter=%0d required 0/0", bus2.busy, bus2.counter);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        trace(1, 1, 0, 0, 16'hA55A, 16'h3C7E, "single_frame");
    endtask

    task automatic test_start_ignored();
        trace(1, 10, 100, 0, 16'h1234, 16'h8001, "start_held");
    endtask

    task automatic test_continuous();
        trace(2, 1, 0, 0, 16'h0FF0, 16'hF00F, "continuous");
    endtask

    task automatic test_counter_sat();
        logic          e_ramp;
        logic [PB-1:0] e_cnt;
        @(negedge clk);
        bus2.start = 1'b1;
        for (int n = 1; n <= 320; n++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            e_ramp = (n >= 8 && n <= 307);
            e_cnt = e_ramp ? PB'((n - 8 > 255) ? 255 : n - 8) : '0;
            checks++;
            if (bus2.ramp_enable !== e_ramp || bus2.counter !== e_cnt) begin
                errors++;
                $display("FAIL counter_sat cycle %0d: got ramp=%b counter=%0d required ramp=%b counter=%0d",
                         n, bus2.ramp_enable, bus2.counter, e_ramp, e_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        trace(1, 1, 0, 300, 16'h5AA5, 16'hC3C3, "pre_reset");
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.erase, bus.expose, bus.ramp_enable, bus.counter, bus.read_row, bus.data_out,
             bus.row_idx, bus.data_valid, bus.frame_done, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got ramp=%b counter=%0d busy=%b data_out=%h required all 0",
                     bus.ramp_enable, bus.counter, bus.busy, bus.data_out);
        end
        reset = 1'b0;
        exp_dout = '0;
        exp_ridx = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.data_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_idle: got valid=%b busy=%b done=%b required 0/0/0",
                         bus.data_valid, bus.busy, bus.frame_done);
            end
        end
        trace(1, 1, 0, 0, 16'h6B2D, 16'h00FF, "post_reset");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.continuous = 1'b0;
        bus.data_in = '0;
        bus2.start = 1'b0;
        bus2.continuous = 1'b0;
        bus2.data_in = '0;
        test_reset();
        test_single_frame();
        test_counter_sat();
        test_start_ignored();
        test_continuous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
